inst_loader: RTL

- Writer side of the fetch unit's instruction store.
- Accepts a stream of DW-bit machine-code words over a valid/ready handshake and writes them into sequential addresses of an internal instruction memory, starting at 0.
- Exposes the same combinational read port the fetch unit already consumes (InstAddress in, InstOut out), so programs load at run time instead of from a file at elaboration.
- Holds the core off (Busy) while a load is in progress.

---
 rtl/inst_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: writer side of the fetch unit's instruction store.
// Accepts a stream of DW-bit machine-code words over a valid/ready handshake
// and writes them to consecutive addresses starting at 0. The combinational
// read port (InstAddress -> InstOut) is the one the fetch unit already uses.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        synchronous, active-low reset
//   Start        single-cycle load request
//   LoadLen      words to load (1..2**IW), sampled on an accepted Start
//   InValid      producer has a word on InData
//   InData       machine-code word
//   InReady      loader accepts a word this cycle
//   InstAddress  fetch read address
//   InstOut      mem[InstAddress], combinational
//   Busy         load in progress, core held
//   Done         last load completed, held until the next load or reset
//   Err          one-cycle pulse after a Start with an illegal LoadLen
//
// state  | meaning
// IDLE   | no load since reset, waiting for Start
// LOAD   | accepting words, Busy/InReady high
// DONE   | load complete, Done high, waiting for Start
module inst_loader #(
  parameter int IW = 10,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW:0]   LoadLen,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  output logic          InReady,
  input  logic [IW-1:0] InstAddress,
  output logic [DW-1:0] InstOut,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW:0] DEPTH = {1'b1, {IW{1'b0}}};

  logic [1:0]    state;
  logic [IW:0]   len_q;
  logic [IW:0]   cnt;
  logic [IW:0]   cnt_nxt;
  logic [IW-1:0] ptr;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          len_legal;
  logic          xfer;

  logic [DW-1:0] mem [2**IW];

  assign len_legal = (LoadLen != '0) && (LoadLen <= DEPTH);
  // busy_q is high exactly in LOAD, so it doubles as the ready qualifier
  assign xfer      = busy_q && InValid;
  assign cnt_nxt   = cnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= S_IDLE;
      len_q  <= '0;
      cnt    <= '0;
      ptr    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            if (len_legal) begin
              state  <= S_LOAD;
              len_q  <= LoadLen;
              cnt    <= '0;
              ptr    <= '0;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            // ptr rolls over only on the final word of a full-depth load,
            // and the FSM leaves LOAD on that same edge
            ptr <= ptr + 1'b1;
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory is never cleared; a reset edge blocks the write of that cycle.
  always_ff @(posedge Clk) begin
    if (Reset && xfer) begin
      mem[ptr] <= InData;
    end
  end

  assign InstOut = mem[InstAddress];
  assign InReady = busy_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule
